uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
UART serial receiver with oversampling. It consumes the one-cycle sample strobe from the baud tick generator at 16x the bit rate. It detects the start bit, samples each data bit at mid-bit, checks the stop bit, and presents the received byte with a one-cycle done strobe. It sits between the async rx pad and the byte-level consumer (FIFO/CPU interface).

Parameters:
DBIT, 8, number of data bits per frame (LSB first), legal 5..8
SB_TICK, 16, s_tick count spanning the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
OS, 16, oversampling ratio (s_tick per bit), power of 2, >=8

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
s_tick  input  1  sample strobe from baud generator, active-high, one clk wide, OS per bit period
rx  input  1  serial line, idle high, asynchronous to clk
dout  output  DBIT  last received data word
rx_done_tick  output  1  one-clk pulse: dout/frame_err updated this cycle
frame_err  output  1  stop bit sampled low on last frame
busy  output  1  high while state != IDLE

Behaviour:
- One clock is used. Reset is asynchronous and active-low: reset_n low clears all flops immediately.
- Reset values: dout=0, rx_done_tick=0, frame_err=0, busy=0, state=IDLE, sync flops=1, s counter=0, n counter=0, shift reg=0.
- rx passes through a 2-flop synchronizer, giving rx_s with 2 clk latency. All decisions use rx_s only.
- s counter is log2(SB_TICK) bits wide, or wider. n counter is ceil(log2(DBIT)) bits wide.
- Counters advance only in clocks where s_tick=1. With s_tick held low, state and counters freeze. The exception is IDLE->START, which does not wait for s_tick.
- IDLE:
  - rx_s==0 in any clk -> START, s=0.
- START:
  - On s_tick with s==OS/2-1: if rx_s==0 -> DATA, s=0, n=0. If rx_s==1 -> IDLE (glitch rejected, no done, outputs unchanged).
  - Other s_tick: s++.
- DATA:
  - On s_tick with s==OS-1: s=0 and shift={rx_s, shift[DBIT-1:1]}, so the LSB arrives first.
  - If n==DBIT-1 -> STOP, else n++.
  - Other s_tick: s++.
- STOP:
  - On s_tick with s==SB_TICK-1, all in the same cycle: dout<=shift, frame_err<=~rx_s, rx_done_tick=1 for exactly that clk, -> IDLE.
  - Other s_tick: s++.
- Sampling point: the start bit is checked at mid-bit; each data bit is sampled OS ticks later, i.e. at its centre.
- dout and frame_err hold their values until the next rx_done_tick. They are not cleared on glitch or on a new start.
- A framing error still delivers the data: dout is updated and frame_err=1.
- Back-to-back frames: a new start bit detected in IDLE the clk after the done pulse is accepted. There is no dead time beyond the remaining stop-bit ticks.
- Break condition (rx held low): the frame completes with dout=0 and frame_err=1. The block then re-enters START immediately because rx_s is still 0, and repeats, each time with frame_err=1.
- Reset mid-frame: the block aborts to IDLE with no done pulse. dout and frame_err return to 0.
- No parity support. No overrun detection; the consumer must take dout before the next rx_done_tick.

Test Plan:
- Frame 0x55 at 16 ticks/bit (s_tick every 4 clk), stop=1 -> exactly one rx_done_tick, dout=0x55, frame_err=0, busy low after the pulse.
- Frame 0xA3 with the stop bit driven 0 -> rx_done_tick=1, dout=0xA3, frame_err=1; the following frame 0x3C with a good stop -> dout=0x3C, frame_err=0.
- rx low for 4 s_ticks then high (glitch) -> no rx_done_tick, state back to IDLE, dout keeps its previous value (0x3C).
- reset_n asserted during data bit 4 of frame 0xF0 -> immediate dout=0, busy=0, no pulse; the next frame 0x81 is received correctly as 0x81.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_done_tick pulses, dout=0x00 then 0xFF, frame_err=0 on both.
- s_tick gated off for 100 clk mid-frame (0x69), then resumed -> no state change during the gap, dout=0x69 received correctly; repeat with DBIT=7 and frame 0x2A -> dout=0x2A.

Source files
------------

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os
// Purpose  : Oversampling UART receiver. Finds the start bit, samples each
//            data bit at its centre, LSB first, and checks the stop bit. Each
//            received word is presented with a one-clock done strobe.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_os #(
   parameter int DBIT    = 8,    // data bits per frame, 5..8
   parameter int SB_TICK = 16,   // s_tick count spanning the stop bit
   parameter int OS      = 16    // s_tick per bit period, power of 2, >= 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            s_tick,
   input  logic            rx,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            busy
);

   // The tick counter must reach both OS-1 and SB_TICK-1.
   localparam int c_S_MAX = (SB_TICK > OS) ? SB_TICK : OS;
   localparam int c_SW    = (c_S_MAX > 2) ? $clog2(c_S_MAX) : 1;
   localparam int c_NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [c_SW-1:0] c_S_ONE  = c_SW'(1);
   localparam logic [c_SW-1:0] c_S_MID  = c_SW'(OS / 2 - 1);
   localparam logic [c_SW-1:0] c_S_BIT  = c_SW'(OS - 1);
   localparam logic [c_SW-1:0] c_S_STOP = c_SW'(SB_TICK - 1);
   localparam logic [c_NW-1:0] c_N_ONE  = c_NW'(1);
   localparam logic [c_NW-1:0] c_N_LAST = c_NW'(DBIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           r_state;
   logic             r_sync1;
   logic             r_sync2;
   logic [c_SW-1:0]  r_s;
   logic [c_NW-1:0]  r_n;
   logic [DBIT-1:0]  r_shift;
   logic [DBIT-1:0]  r_dout;
   logic             r_done;
   logic             r_ferr;
   logic             r_busy;
   logic             w_rx_s;

   // Synchronised serial line; idle level is high so the flops reset to 1.
   assign w_rx_s = r_sync2;

   // Two-flop synchroniser for the asynchronous rx pad.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   // Receive state machine with registered outputs; counters only move on s_tick,
   // except the IDLE->START entry which reacts to the first low rx_s.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_shift <= '0;
         r_dout  <= '0;
         r_done  <= 1'b0;
         r_ferr  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_rx_s) begin
                  r_state <= START;
                  r_s     <= '0;
                  r_busy  <= 1'b1;
               end
            end
            START: begin
               if (s_tick) begin
                  if (r_s == c_S_MID) begin
                     if (!w_rx_s) begin
                        r_state <= DATA;
                        r_s     <= '0;
                        r_n     <= '0;
                     end else begin
                        // Start bit no longer low at mid-bit: treat as a glitch.
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_s <= r_s + c_S_ONE;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (r_s == c_S_BIT) begin
                     r_s     <= '0;
                     r_shift <= {w_rx_s, r_shift[DBIT-1:1]};
                     if (r_n == c_N_LAST) begin
                        r_state <= STOP;
                     end else begin
                        r_n <= r_n + c_N_ONE;
                     end
                  end else begin
                     r_s <= r_s + c_S_ONE;
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (r_s == c_S_STOP) begin
                     // Data is delivered even when the stop bit is bad.
                     r_dout  <= r_shift;
                     r_ferr  <= ~w_rx_s;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_s <= r_s + c_S_ONE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign dout         = r_dout;
   assign rx_done_tick = r_done;
   assign frame_err    = r_ferr;
   assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_os
// Purpose  : Directed bench for uart_rx_os (DBIT=8 and DBIT=7 instances),
//            16 s_tick per bit with s_tick every 4 clk (64 clk per bit).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_os;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       s_tick = 1'b0;
   logic       tick_en;
   logic [1:0] tick_cnt = 2'd0;
   logic       rx1;
   logic       rx2;

   logic [7:0] dout1;
   logic       done1;
   logic       ferr1;
   logic       busy1;
   logic [6:0] dout2;
   logic       done2;
   logic       ferr2;
   logic       busy2;

   logic [7:0] q1_d[$];
   logic       q1_f[$];
   logic [7:0] q2_d[$];
   logic       q2_f[$];

   int n_cmp = 0;
   int n_mis = 0;

   typedef struct {
      logic [7:0] data;
      logic       stop_ok;
      logic [7:0] exp_dout;
      logic       exp_fe;
   } vec_t;

   vec_t tbl[3];

   uart_rx_os #(.DBIT(8), .SB_TICK(16), .OS(16)) dut8 (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_tick       (s_tick),
      .rx           (rx1),
      .dout         (dout1),
      .rx_done_tick (done1),
      .frame_err    (ferr1),
      .busy         (busy1)
   );

   uart_rx_os #(.DBIT(7), .SB_TICK(16), .OS(16)) dut7 (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_tick       (s_tick),
      .rx           (rx2),
      .dout         (dout2),
      .rx_done_tick (done2),
      .frame_err    (ferr2),
      .busy         (busy2)
   );

   always #5 clk = ~clk;

   // One-clock s_tick every 4 clk; gating freezes the phase.
   always @(negedge clk) begin
      if (tick_en) begin
         tick_cnt <= tick_cnt + 2'd1;
         s_tick   <= (tick_cnt == 2'd3);
      end else begin
         s_tick <= 1'b0;
      end
   end

   // Record every done-cycle with the word presented alongside it.
   always @(negedge clk) begin
      if (done1) begin
         q1_d.push_back(dout1);
         q1_f.push_back(ferr1);
      end
      if (done2) begin
         q2_d.push_back({1'b0, dout2});
         q2_f.push_back(ferr2);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_line(input int which, input logic v);
      if (which == 2) rx2 = v;
      else            rx1 = v;
   endtask

   // One frame, 64 clk per bit. A bad stop bit is low for 40 clk then high.
   // gate_bit >= 0 stops s_tick for 100 clk inside that data bit.
   task automatic send_frame(input int which, input logic [7:0] data, input int nbits,
                             input logic stop_ok, input int gate_bit);
      int qn;
      set_line(which, 1'b0);
      hold(64);
      for (int i = 0; i < nbits; i++) begin
         set_line(which, data[i]);
         if (i == gate_bit) begin
            hold(20);
            tick_en = 1'b0;
            hold(100);
            qn = (which == 2) ? q2_d.size() : q1_d.size();
            chk("gap_busy", (which == 2) ? busy2 : busy1, 1);
            chk("gap_no_done", qn, 0);
            tick_en = 1'b1;
            hold(44);
         end else begin
            hold(64);
         end
      end
      if (stop_ok) begin
         set_line(which, 1'b1);
         hold(64);
      end else begin
         set_line(which, 1'b0);
         hold(40);
         set_line(which, 1'b1);
         hold(24);
      end
   endtask

   task automatic clear_q();
      q1_d.delete();
      q1_f.delete();
      q2_d.delete();
      q2_f.delete();
   endtask

   initial begin
      logic [7:0] d;

      tbl[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
      tbl[1] = '{8'hA3, 1'b0, 8'hA3, 1'b1};
      tbl[2] = '{8'h3C, 1'b1, 8'h3C, 1'b0};

      reset_n = 1'b0;
      rx1     = 1'b1;
      rx2     = 1'b1;
      tick_en = 1'b1;
      hold(4);
      chk("rst_dout8", dout1, 0);
      chk("rst_done8", done1, 0);
      chk("rst_ferr8", ferr1, 0);
      chk("rst_busy8", busy1, 0);
      chk("rst_dout7", dout2, 0);
      chk("rst_done7", done2, 0);
      chk("rst_ferr7", ferr2, 0);
      chk("rst_busy7", busy2, 0);
      reset_n = 1'b1;
      hold(64);

      // Table: good frame, framing error, good frame after error.
      for (int v = 0; v < 3; v++) begin
         clear_q();
         send_frame(1, tbl[v].data, 8, tbl[v].stop_ok, -1);
         hold(128);
         chk("tbl_done_count", q1_d.size(), 1);
         chk("tbl_dout", dout1, tbl[v].exp_dout);
         chk("tbl_frame_err", ferr1, tbl[v].exp_fe);
         chk("tbl_busy_after", busy1, 0);
      end

      // Glitch: rx low for 4 s_tick only.
      clear_q();
      set_line(1, 1'b0);
      hold(8);
      chk("glitch_busy_seen", busy1, 1);
      hold(8);
      set_line(1, 1'b1);
      hold(100);
      chk("glitch_no_done", q1_d.size(), 0);
      chk("glitch_busy", busy1, 0);
      chk("glitch_dout_kept", dout1, 8'h3C);
      chk("glitch_ferr_kept", ferr1, 0);

      // Reset in the middle of data bit 4 of 0xF0.
      clear_q();
      d = 8'hF0;
      set_line(1, 1'b0);
      hold(64);
      for (int i = 0; i < 4; i++) begin
         set_line(1, d[i]);
         hold(64);
      end
      set_line(1, d[4]);
      hold(32);
      chk("pre_rst_busy", busy1, 1);
      reset_n = 1'b0;
      #1;
      chk("midrst_dout", dout1, 0);
      chk("midrst_busy", busy1, 0);
      chk("midrst_ferr", ferr1, 0);
      set_line(1, 1'b1);
      hold(10);
      reset_n = 1'b1;
      hold(64);
      chk("midrst_no_done", q1_d.size(), 0);
      send_frame(1, 8'h81, 8, 1'b1, -1);
      hold(128);
      chk("post_rst_count", q1_d.size(), 1);
      chk("post_rst_dout", dout1, 8'h81);
      chk("post_rst_ferr", ferr1, 0);

      // Back-to-back 0x00 then 0xFF with no idle gap.
      clear_q();
      send_frame(1, 8'h00, 8, 1'b1, -1);
      send_frame(1, 8'hFF, 8, 1'b1, -1);
      hold(128);
      chk("b2b_count", q1_d.size(), 2);
      chk("b2b_dout0", q1_d[0], 8'h00);
      chk("b2b_ferr0", q1_f[0], 0);
      chk("b2b_dout1", q1_d[1], 8'hFF);
      chk("b2b_ferr1", q1_f[1], 0);

      // s_tick gated off for 100 clk mid-frame, DBIT=8.
      clear_q();
      send_frame(1, 8'h69, 8, 1'b1, 3);
      hold(128);
      chk("gate8_count", q1_d.size(), 1);
      chk("gate8_dout", dout1, 8'h69);
      chk("gate8_ferr", ferr1, 0);

      // Same with the DBIT=7 instance.
      clear_q();
      send_frame(2, 8'h2A, 7, 1'b1, 2);
      hold(128);
      chk("gate7_count", q2_d.size(), 1);
      chk("gate7_dout", dout2, 7'h2A);
      chk("gate7_ferr", ferr2, 0);
      chk("gate7_other_idle", q1_d.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
